mem_store_seq: RTL and testbench
================================

MEM_STORE_SEQ -- requirements
Module: mem_store_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit, reset, asynchronous and active-high.
REQ-003 SHALL have port req_valid, input, 1 bit, store request present.
REQ-004 SHALL have port req_ready, output, 1 bit, sequencer can accept a request.
REQ-005 SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 reserved.
REQ-006 SHALL have port req_addr, input, 32 bits, byte address of the store.
REQ-007 SHALL have port req_data, input, 32 bits, store data, right-justified.
REQ-008 SHALL have port mem_wvalid, output, 1 bit, word write presented to memory.
REQ-009 SHALL have port mem_wready, input, 1 bit, memory accepts the write.
REQ-010 SHALL have port mem_waddr, output, 32 bits, word-aligned address; bits [1:0] are always 0.
REQ-011 SHALL have port mem_wdata, output, 32 bits, lane-shifted write data.
REQ-012 SHALL have port mem_wbe, output, 4 bits, per-byte write enables.
REQ-013 SHALL have port done, output, 1 bit, one-cycle completion pulse.
REQ-014 SHALL have port split_cnt, output, 16 bits, count of stores split into two writes.

Function
REQ-015 SHALL implement FSM states IDLE, FIRST and SECOND.
REQ-016 SHALL drive req_ready=1 only in IDLE.
REQ-017 SHALL capture size, address and data on req_valid && req_ready, then enter FIRST, or return to IDLE for size 11.
REQ-018 SHALL derive the base mask from size (0001, 0011, 1111) and the offset off=addr[1:0].
REQ-019 SHALL form an 8-bit mask m8 = base << off and 64-bit data d64 = data << 8*off.
REQ-020 SHALL in FIRST drive mem_wvalid=1, mem_waddr={addr[31:2],00}, mem_wbe=m8[3:0] and mem_wdata=d64[31:0].
REQ-021 SHALL in SECOND drive mem_wvalid=1, mem_waddr={addr[31:2],00}+4, mem_wbe=m8[7:4] and mem_wdata=d64[63:32].
REQ-022 SHALL advance on mem_wvalid && mem_wready: FIRST goes to SECOND if m8[7:4]!=0, else to IDLE; SECOND goes to IDLE.
REQ-023 SHALL hold mem_waddr, mem_wdata and mem_wbe stable while mem_wvalid && !mem_wready.
REQ-024 SHALL drive mem_wvalid=0, mem_wbe=0, mem_waddr=0 and mem_wdata=0 in IDLE.
REQ-025 SHALL pulse done for exactly one cycle in the cycle after the final write handshake, or after acceptance of a size-11 request; a size-11 request produces no write.
REQ-026 SHALL present the first write in the cycle after acceptance; an aligned store with mem_wready=1 therefore completes in 2 cycles, giving back-to-back throughput of one store per 2 cycles.
REQ-027 SHALL accept a new request in the same cycle that done is high.
REQ-028 SHALL increment split_cnt when a write enters SECOND, and saturate it at 0xFFFF.
REQ-029 SHALL ignore req_valid while not in IDLE, with no capture and no error.
REQ-030 SHALL compute address wrap-around of +4 past 0xFFFFFFFC modulo 2^32, giving 0x00000000.

Reset
REQ-031 SHALL on rst, immediately and independent of clk, enter IDLE and force mem_wvalid=0, mem_wbe=0, mem_waddr=0, mem_wdata=0, done=0, split_cnt=0 and req_ready=1.
REQ-032 SHALL discard any in-flight store on reset mid-operation, including one in SECOND, without issuing a partial second write.

Structure
REQ-033 SHALL take the size encodings, FSM state encodings and the split_cnt width constant from a shared package, store_pkg.
REQ-034 SHALL place the mask/data shift logic (REQ-018, REQ-019) in one combinational sub-module, store_lane_gen; all sequencing stays in mem_store_seq.

Verification
REQ-035 SHALL verify that sb addr 0x00001003 data 0x000000AB produces one write at 0x00001000, be 1000, data 0xAB000000, then a done pulse and split_cnt=0.
REQ-036 SHALL verify that sh addr 0x00002003 data 0x0000BEEF produces a write at 0x00002000, be 1000, data 0xEF000000, then a write at 0x00002004, be 0001, data 0x000000BE, then done and split_cnt=1.
REQ-037 SHALL verify that sw addr 0x00003002 data 0x11223344 produces a write at 0x00003000, be 1100, data 0x33440000, then a write at 0x00003004, be 0011, data 0x00001122.
REQ-038 SHALL verify that holding mem_wready=0 for 3 cycles during FIRST of the REQ-036 store keeps address, data and be unchanged, keeps req_ready=0, and produces no done pulse.
REQ-039 SHALL verify that asserting rst while in SECOND forces mem_wvalid=0 and split_cnt=0 in the same cycle, that no 0x00002004 write occurs, and that req_ready=1 afterwards.
REQ-040 SHALL verify that back-to-back aligned sw at 0x00004000 and 0x00004004 with mem_wready=1 are both written with be 1111, with done pulses 2 cycles apart.

Source files
------------

// File: rtl/store_pkg.sv
// store_pkg
// Shared definitions for the store sequencer: request size encodings,
// sequencer state encodings, the split counter width and the base
// byte-mask helper used by the lane generator.
package store_pkg;

    // Request size encodings carried on req_size.
    typedef enum logic [1:0] {
        SIZE_B   = 2'b00,
        SIZE_H   = 2'b01,
        SIZE_W   = 2'b10,
        SIZE_RSV = 2'b11
    } size_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FIRST  = 2'b01,
        ST_SECOND = 2'b10
    } state_e;

    localparam int SPLIT_CNT_W = 16;
    localparam logic [SPLIT_CNT_W-1:0] SPLIT_CNT_MAX = '1;

    // Unshifted byte-enable pattern for a store of the given size.
    // The reserved encoding enables no bytes.
    function automatic logic [3:0] base_mask(input logic [1:0] size);
        logic [3:0] m;
        case (size)
            SIZE_B:  m = 4'b0001;
            SIZE_H:  m = 4'b0011;
            SIZE_W:  m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/store_lane_gen.sv
// store_lane_gen
// Purely combinational lane placement for a store request. The byte
// mask and the right-justified data are shifted by the byte offset into
// an 8-lane / 64-bit window spanning the addressed word and the next one.
// Ports:
//   size  - request size encoding (store_pkg::size_e values)
//   off   - byte offset within the word (addr[1:0])
//   data  - right-justified store data
//   m8    - byte enables for the two-word window, [3:0] first word
//   d64   - lane-shifted data for the two-word window, [31:0] first word
module store_lane_gen
    import store_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] data,
    output logic [7:0]  m8,
    output logic [63:0] d64
);

    logic [3:0] base;

    always_comb begin
        base = base_mask(size);
        m8   = {4'b0000, base} << off;
        d64  = {32'h0, data} << {off, 3'b000};
    end

endmodule

// File: rtl/mem_store_seq.sv
// mem_store_seq
// Converts byte/half/word store requests at arbitrary byte addresses into
// one or two word-aligned memory writes with per-byte enables. A store
// that crosses a word boundary is split into a FIRST write (lower word)
// and a SECOND write (next word, address wraps modulo 2^32).
// Ports:
//   clk, rst                         - clock, asynchronous active-high reset
//   req_valid/req_ready              - request handshake (ready only in IDLE)
//   req_size, req_addr, req_data     - store request fields
//   mem_wvalid/mem_wready            - memory write handshake
//   mem_waddr, mem_wdata, mem_wbe    - word-aligned write, lane data, enables
//   done                             - one-cycle pulse after store completion
//   split_cnt                        - saturating count of split stores
module mem_store_seq
    import store_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_size,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_data,
    output logic                   mem_wvalid,
    input  logic                   mem_wready,
    output logic [31:0]            mem_waddr,
    output logic [31:0]            mem_wdata,
    output logic [3:0]             mem_wbe,
    output logic                   done,
    output logic [SPLIT_CNT_W-1:0] split_cnt
);

    state_e      state;
    logic [7:0]  lane_m8;
    logic [63:0] lane_d64;
    // Upper half of the lane window, held for the SECOND write.
    logic [3:0]  hi_be;
    logic [31:0] hi_data;

    // Lanes are computed from the live request so the FIRST write can be
    // registered directly at acceptance, one cycle after the handshake.
    store_lane_gen u_lane_gen (
        .size (req_size),
        .off  (req_addr[1:0]),
        .data (req_data),
        .m8   (lane_m8),
        .d64  (lane_d64)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            mem_wvalid <= 1'b0;
            mem_waddr  <= 32'h0;
            mem_wdata  <= 32'h0;
            mem_wbe    <= 4'h0;
            done       <= 1'b0;
            split_cnt  <= '0;
            hi_be      <= 4'h0;
            hi_data    <= 32'h0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (req_size == SIZE_RSV) begin
                            // Reserved size: accepted and completed, no write.
                            done <= 1'b1;
                        end else begin
                            state      <= ST_FIRST;
                            req_ready  <= 1'b0;
                            mem_wvalid <= 1'b1;
                            mem_waddr  <= {req_addr[31:2], 2'b00};
                            mem_wbe    <= lane_m8[3:0];
                            mem_wdata  <= lane_d64[31:0];
                            hi_be      <= lane_m8[7:4];
                            hi_data    <= lane_d64[63:32];
                        end
                    end
                end
                ST_FIRST: begin
                    if (mem_wready) begin
                        if (hi_be != 4'h0) begin
                            state     <= ST_SECOND;
                            mem_waddr <= mem_waddr + 32'd4;
                            mem_wbe   <= hi_be;
                            mem_wdata <= hi_data;
                            if (split_cnt != SPLIT_CNT_MAX) begin
                                split_cnt <= split_cnt + 1'b1;
                            end
                        end else begin
                            state      <= ST_IDLE;
                            req_ready  <= 1'b1;
                            mem_wvalid <= 1'b0;
                            mem_waddr  <= 32'h0;
                            mem_wdata  <= 32'h0;
                            mem_wbe    <= 4'h0;
                            done       <= 1'b1;
                        end
                    end
                end
                ST_SECOND: begin
                    if (mem_wready) begin
                        state      <= ST_IDLE;
                        req_ready  <= 1'b1;
                        mem_wvalid <= 1'b0;
                        mem_waddr  <= 32'h0;
                        mem_wdata  <= 32'h0;
                        mem_wbe    <= 4'h0;
                        done       <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    req_ready  <= 1'b1;
                    mem_wvalid <= 1'b0;
                    mem_waddr  <= 32'h0;
                    mem_wdata  <= 32'h0;
                    mem_wbe    <= 4'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_store_seq.sv
module tb_mem_store_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wbe;
    logic        done;
    logic [15:0] split_cnt;

    mem_store_seq dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .mem_wvalid (mem_wvalid),
        .mem_wready (mem_wready),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_wbe    (mem_wbe),
        .done       (done),
        .split_cnt  (split_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        int          nw;
        wr_t         w0;
        wr_t         w1;
    } vec_t;

    wr_t  exp_q[$];
    int   done_cyc_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   wr_total = 0;
    int   exp_split = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    always @(posedge clk) cyc++;

    // Handshake monitor: a write seen valid and ready here is taken on the
    // coming rising edge, so it is popped from the scoreboard now.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_cyc_q.push_back(cyc);
            if (mem_wvalid && mem_wready) begin
                wr_t e;
                wr_total++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_addr", mem_waddr, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", mem_waddr, e.addr);
                    chk("wr_be", {28'h0, mem_wbe}, {28'h0, e.be});
                    chk("wr_data", mem_wdata, e.data);
                end
            end
        end
    end

    task automatic send(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (req_ready) got = 1;
        end
        chk("req_ready_wait", {31'h0, got}, 32'h1);
        req_valid = 1'b1;
        req_size  = size;
        req_addr  = addr;
        req_data  = data;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("done_seen", {31'h0, seen}, 32'h1);
    endtask

    task automatic push_vec(input vec_t v);
        if (v.nw > 0) exp_q.push_back(v.w0);
        if (v.nw > 1) exp_q.push_back(v.w1);
    endtask

    vec_t vecs[8];
    int   wr_before;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d, required below 20000", cyc);
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_size   = 2'b00;
        req_addr   = 32'h0;
        req_data   = 32'h0;
        mem_wready = 1'b1;

        vecs[0] = '{2'b00, 32'h0000_1003, 32'h0000_00AB, 1,
                    '{32'h0000_1000, 4'b1000, 32'hAB00_0000}, '{32'h0, 4'h0, 32'h0}};
        vecs[1] = '{2'b01, 32'h0000_2003, 32'h0000_BEEF, 2,
                    '{32'h0000_2000, 4'b1000, 32'hEF00_0000}, '{32'h0000_2004, 4'b0001, 32'h0000_00BE}};
        vecs[2] = '{2'b10, 32'h0000_3002, 32'h1122_3344, 2,
                    '{32'h0000_3000, 4'b1100, 32'h3344_0000}, '{32'h0000_3004, 4'b0011, 32'h0000_1122}};
        vecs[3] = '{2'b01, 32'h0000_5002, 32'h0000_1234, 1,
                    '{32'h0000_5000, 4'b1100, 32'h1234_0000}, '{32'h0, 4'h0, 32'h0}};
        vecs[4] = '{2'b10, 32'h0000_6000, 32'hDEAD_BEEF, 1,
                    '{32'h0000_6000, 4'b1111, 32'hDEAD_BEEF}, '{32'h0, 4'h0, 32'h0}};
        vecs[5] = '{2'b00, 32'h0000_7001, 32'h0000_005A, 1,
                    '{32'h0000_7000, 4'b0010, 32'h0000_5A00}, '{32'h0, 4'h0, 32'h0}};
        vecs[6] = '{2'b10, 32'hFFFF_FFFE, 32'hAABB_CCDD, 2,
                    '{32'hFFFF_FFFC, 4'b1100, 32'hCCDD_0000}, '{32'h0000_0000, 4'b0011, 32'h0000_AABB}};
        vecs[7] = '{2'b11, 32'h0000_8000, 32'h1234_5678, 0,
                    '{32'h0, 4'h0, 32'h0}, '{32'h0, 4'h0, 32'h0}};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_wvalid", {31'h0, mem_wvalid}, 32'h0);
        chk("rst_waddr", mem_waddr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_wbe", {28'h0, mem_wbe}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_split_cnt", {16'h0, split_cnt}, 32'h0);
        rst = 1'b0;

        // Table-driven stores
        for (int i = 0; i < 8; i++) begin
            push_vec(vecs[i]);
            if (vecs[i].nw == 2) exp_split++;
            send(vecs[i].size, vecs[i].addr, vecs[i].data);
            wait_done();
            chk("writes_consumed", exp_q.size(), 32'h0);
            chk("split_cnt", {16'h0, split_cnt}, exp_split);
            @(negedge clk);
            chk("done_one_cycle", {31'h0, done}, 32'h0);
        end

        // Stall in FIRST for 3 cycles
        mem_wready = 1'b0;
        push_vec(vecs[1]);
        exp_split++;
        send(2'b01, 32'h0000_2003, 32'h0000_BEEF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_wvalid", {31'h0, mem_wvalid}, 32'h1);
            chk("stall_addr", mem_waddr, 32'h0000_2000);
            chk("stall_be", {28'h0, mem_wbe}, 32'h8);
            chk("stall_data", mem_wdata, 32'hEF00_0000);
            chk("stall_req_ready", {31'h0, req_ready}, 32'h0);
            chk("stall_no_done", {31'h0, done}, 32'h0);
        end
        @(posedge clk);
        #1;
        mem_wready = 1'b1;
        wait_done();
        chk("stall_consumed", exp_q.size(), 32'h0);
        chk("stall_split_cnt", {16'h0, split_cnt}, exp_split);

        // Reset while in SECOND
        exp_q.push_back(vecs[1].w0);
        send(2'b01, 32'h0000_2003, 32'h0000_BEEF);
        @(posedge clk);
        #1;
        mem_wready = 1'b0;
        @(negedge clk);
        chk("second_addr", mem_waddr, 32'h0000_2004);
        chk("second_split_cnt", {16'h0, split_cnt}, exp_split + 1);
        wr_before = wr_total;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_wvalid", {31'h0, mem_wvalid}, 32'h0);
        chk("midrst_split_cnt", {16'h0, split_cnt}, 32'h0);
        chk("midrst_req_ready", {31'h0, req_ready}, 32'h1);
        exp_split = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_wready = 1'b1;
        repeat (5) @(negedge clk);
        chk("no_write_after_rst", wr_total, wr_before);
        chk("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("post_rst_queue", exp_q.size(), 32'h0);

        // Back-to-back aligned words
        done_cyc_q.delete();
        exp_q.push_back('{32'h0000_4000, 4'b1111, 32'hCAFE_0001});
        exp_q.push_back('{32'h0000_4004, 4'b1111, 32'hCAFE_0002});
        send(2'b10, 32'h0000_4000, 32'hCAFE_0001);
        send(2'b10, 32'h0000_4004, 32'hCAFE_0002);
        for (int i = 0; i < 40 && done_cyc_q.size() < 2; i++) @(negedge clk);
        chk("b2b_done_count", done_cyc_q.size(), 32'h2);
        if (done_cyc_q.size() >= 2)
            chk("b2b_done_spacing", done_cyc_q[1] - done_cyc_q[0], 32'h2);
        chk("b2b_consumed", exp_q.size(), 32'h0);
        chk("b2b_split_cnt", {16'h0, split_cnt}, exp_split);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
